// File: rtl/regfile_write_port_pkg.sv
// Shared constants and types for the posted-write register file.
// The optional REGFILE_R0_ZERO_EN build is handled in regfile_write_port.
package regfile_write_port_pkg;

    localparam int NUM_REGS    = 8;
    localparam int ADDR_W      = 3;
    localparam int BUF_ENTRIES = 2;
    localparam int PTR_W       = 1;
    localparam int CNT_W       = 2;

    // Entries carry data at this width; the top narrows it to DEPTH, so DEPTH must not exceed it.
    localparam int DATA_W_MAX  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W_MAX-1:0] data;
    } wbuf_entry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/regfile_write_port_wbuf.sv
// Two-entry posted-write FIFO: head/tail pointers, occupancy count, full/empty,
// and per-slot valid/address so the parent can build a pending-register mask.
module regfile_wbuf
    import regfile_write_port_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  wbuf_entry_t                          push_entry,
    input  logic                                 pop,
    output wbuf_entry_t                          head_entry,
    output logic [BUF_ENTRIES-1:0]               entry_valid,
    output logic [BUF_ENTRIES-1:0][ADDR_W-1:0]   entry_addr,
    output logic                                 full,
    output logic                                 empty
);

    wbuf_entry_t       mem_reg [BUF_ENTRIES];
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == CNT_W'(BUF_ENTRIES));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop_ok) begin
            head_next = head_reg + 1'b1;
        end
        if (push_ok) begin
            tail_next = tail_reg + 1'b1;
        end
        count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload storage needs no reset: slots are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[tail_reg] <= push_entry;
        end
    end

    assign head_entry = mem_reg[head_reg];

    generate
        for (genvar gi = 0; gi < BUF_ENTRIES; gi++) begin : g_slot
            assign entry_addr[gi]  = mem_reg[gi].addr;
            assign entry_valid[gi] = (count_reg == CNT_W'(BUF_ENTRIES)) ||
                                     ((count_reg == CNT_W'(1)) && (head_reg == PTR_W'(gi)));
        end
    endgenerate

endmodule

// File: rtl/regfile_write_port.sv
// Eight-register file with a two-entry posted-write buffer in front of it.
// Define REGFILE_R0_ZERO_EN to make register 0 read as constant zero.
module regfile_write_port
    import regfile_write_port_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int BUF_ENTRIES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [2:0]        WA,
    input  logic [DEPTH-1:0]  WD,
    output logic              wr_ready,
    input  logic              commit_en,
    output logic [DEPTH-1:0]  Dout0,
    output logic [DEPTH-1:0]  Dout1,
    output logic [DEPTH-1:0]  Dout2,
    output logic [DEPTH-1:0]  Dout3,
    output logic [DEPTH-1:0]  Dout4,
    output logic [DEPTH-1:0]  Dout5,
    output logic [DEPTH-1:0]  Dout6,
    output logic [DEPTH-1:0]  Dout7,
    output logic [7:0]        pend_mask,
    output logic              buf_empty,
    output logic              buf_full
);

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    wbuf_entry_t                               push_entry;
    wbuf_entry_t                               head_entry;
    logic [BUF_ENTRIES-1:0]                    entry_valid;
    logic [BUF_ENTRIES-1:0][ADDR_W-1:0]        entry_addr;
    logic                                      accept;
    logic                                      commit;
    logic [DEPTH-1:0]                          head_data;
    logic [NUM_REGS-1:0]                       commit_hot;
    logic [DEPTH-1:0]                          dout_arr [NUM_REGS];

    // Reset masks ready so a requester never sees a slot while the buffer is being cleared.
    assign wr_ready   = !buf_full && !rst;
    assign accept     = wr_valid && wr_ready;
    assign commit     = commit_en && !buf_empty;

    assign push_entry = '{addr: WA, data: DATA_W_MAX'(WD)};
    assign head_data  = DEPTH'(head_entry.data);
    assign commit_hot = commit ? addr_onehot(head_entry.addr) : '0;

    regfile_wbuf u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push        (accept),
        .push_entry  (push_entry),
        .pop         (commit),
        .head_entry  (head_entry),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr),
        .full        (buf_full),
        .empty       (buf_empty)
    );

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // With R0_ZERO the commit to register 0 still pops the entry; only the write is dropped.
            localparam bit WRITABLE = !(R0_ZERO && (gi == 0));
            logic [DEPTH-1:0] r_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_reg <= '0;
                end else if (WRITABLE && commit_hot[gi]) begin
                    r_reg <= head_data;
                end
            end

            assign dout_arr[gi] = r_reg;
        end
    endgenerate

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < BUF_ENTRIES; i++) begin
            if (entry_valid[i]) begin
                pend_mask = pend_mask | addr_onehot(entry_addr[i]);
            end
        end
    end

    assign Dout0 = dout_arr[0];
    assign Dout1 = dout_arr[1];
    assign Dout2 = dout_arr[2];
    assign Dout3 = dout_arr[3];
    assign Dout4 = dout_arr[4];
    assign Dout5 = dout_arr[5];
    assign Dout6 = dout_arr[6];
    assign Dout7 = dout_arr[7];

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: a queue-based reference model predicts the
// visible state each cycle, and a monitor compares it against the DUT on the falling edge.
module tb_regfile_write_port;

    localparam int DEPTH = 4;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [2:0]       WA;
    logic [DEPTH-1:0] WD;
    logic             wr_ready;
    logic             commit_en;
    logic [DEPTH-1:0] Dout0, Dout1, Dout2, Dout3, Dout4, Dout5, Dout6, Dout7;
    logic [7:0]       pend_mask;
    logic             buf_empty;
    logic             buf_full;

    always #5 clk = ~clk;

    regfile_write_port #(.DEPTH(DEPTH), .BUF_ENTRIES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .WA        (WA),
        .WD        (WD),
        .wr_ready  (wr_ready),
        .commit_en (commit_en),
        .Dout0     (Dout0),
        .Dout1     (Dout1),
        .Dout2     (Dout2),
        .Dout3     (Dout3),
        .Dout4     (Dout4),
        .Dout5     (Dout5),
        .Dout6     (Dout6),
        .Dout7     (Dout7),
        .pend_mask (pend_mask),
        .buf_empty (buf_empty),
        .buf_full  (buf_full)
    );

    typedef struct {
        int          cyc;
        logic [31:0] dout;
        logic [7:0]  pend;
        logic        full;
        logic        empty;
        logic        ready;
    } exp_t;

    typedef struct {
        logic [2:0]       a;
        logic [DEPTH-1:0] d;
    } ent_t;

    exp_t             exp_q[$];
    ent_t             mq[$];
    logic [DEPTH-1:0] mregs [8];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;

    function automatic logic [31:0] model_dout();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = mregs[i];
        return r;
    endfunction

    function automatic logic [7:0] model_pend();
        logic [7:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        return p;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.cyc   = cyc;
        e.dout  = model_dout();
        e.pend  = model_pend();
        e.full  = (mq.size() == 2);
        e.empty = (mq.size() == 0);
        e.ready = !rst && (mq.size() < 2);
        exp_q.push_back(e);
    endtask

    task automatic set_rst(input logic val);
        rst = val;
        if (val) begin
            mq.delete();
            for (int i = 0; i < 8; i++) mregs[i] = '0;
        end
    endtask

    // Called just after a rising edge: drive, predict the visible state, then advance across the next edge.
    task automatic step(input logic v, input logic [2:0] a, input logic [DEPTH-1:0] d, input logic ce);
        logic acc, com;
        ent_t h;
        ent_t n;
        wr_valid  = v;
        WA        = a;
        WD        = d;
        commit_en = ce;
        push_expected();
        acc = !rst && v && (mq.size() < 2);
        com = !rst && ce && (mq.size() > 0);
        @(posedge clk);
        if (com) begin
            h = mq.pop_front();
            if (!(R0Z && h.a == 3'd0)) mregs[h.a] = h.d;
        end
        if (acc) begin
            n.a = a;
            n.d = d;
            mq.push_back(n);
        end
        cyc++;
        #1;
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
        end
    endtask

    // Monitor: the DUT presents its state every cycle; compare whenever a prediction is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout",      e.cyc, {Dout7, Dout6, Dout5, Dout4, Dout3, Dout2, Dout1, Dout0}, e.dout);
                check("pend_mask", e.cyc, 32'(pend_mask), 32'(e.pend));
                check("buf_full",  e.cyc, 32'(buf_full),  32'(e.full));
                check("buf_empty", e.cyc, 32'(buf_empty), 32'(e.empty));
                check("wr_ready",  e.cyc, 32'(wr_ready),  32'(e.ready));
                $display("cyc %0d rst=%0b v=%0b WA=%0d WD=%h ce=%0b rdy=%0b pend=%h dout=%h",
                         e.cyc, rst, wr_valid, WA, WD, commit_en, wr_ready, pend_mask,
                         {Dout7, Dout6, Dout5, Dout4, Dout3, Dout2, Dout1, Dout0});
            end
        end
    end

    initial begin
        wr_valid  = 1'b0;
        WA        = '0;
        WD        = '0;
        commit_en = 1'b0;
        set_rst(1'b1);
        @(posedge clk);
        #1;
        step(1'b1, 3'd5, 4'h3, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        set_rst(1'b0);

        // Single write lands one edge after accept.
        step(1'b1, 3'd3, 4'hA, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);

        // Held buffer fills, blocks, then drains in order.
        step(1'b1, 3'd1, 4'h5, 1'b0);
        step(1'b1, 3'd2, 4'h6, 1'b0);
        step(1'b1, 3'd7, 4'h9, 1'b0);
        step(1'b1, 3'd7, 4'h9, 1'b1);
        step(1'b1, 3'd7, 4'h9, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);

        // Same register twice back to back.
        step(1'b1, 3'd4, 4'h1, 1'b1);
        step(1'b1, 3'd4, 4'hF, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);

        // Steady stream of 16 writes.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 1'b1);
        end
        step(1'b0, 3'd0, 4'h0, 1'b1);

        // Full buffer discarded by a mid-cycle reset pulse.
        step(1'b1, 3'd6, 4'hC, 1'b0);
        step(1'b1, 3'd5, 4'hD, 1'b0);
        set_rst(1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        set_rst(1'b0);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);

        // Register 0 write.
        step(1'b1, 3'd0, 4'h7, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b0, 3'd0, 4'h0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                set_rst(1'b1);
                step(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 1'b1);
                set_rst(1'b0);
            end
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
